// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing generator.
//   Divides clk by CLK_DIV to a pixel enable, runs hCount/vCount, derives
//   bright, and outputs the renderer colour to the DAC one pixel later,
//   aligned with hSync/vSync. frame_tick marks each raster wrap to (0,0).
// Ports:
//   clk        system clock (100 MHz)
//   rst        asynchronous active-low reset
//   rgb_in     renderer colour for current (hCount,vCount)
//   hCount     pixel column 0..H_TOTAL-1
//   vCount     line 0..V_TOTAL-1
//   bright     current (hCount,vCount) is inside active video
//   pix_tick   1-clk strobe once every CLK_DIV clks
//   frame_tick 1-clk strobe in the first clk at (0,0) after a wrap
//   hSync      active-low horizontal sync, one pixel delayed
//   vSync      active-low vertical sync, one pixel delayed
//   rgb_out    DAC colour, one pixel delayed, zero in blanking
// Build option: define VGA_TEST_PATTERN_EN to replace rgb_in with 8
//   vertical colour bars across the active area.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_DISP_START = 144,
  parameter int unsigned H_DISP_END   = 784,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_DISP_START = 35,
  parameter int unsigned V_DISP_END   = 515
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] rgb_out
);

  localparam int unsigned CW    = 10;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BAR_W = (H_DISP_END - H_DISP_START) / 8;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    h_q, h_d, v_q, v_d;
  logic             bright_q, bright_d;
  logic             pix_q, pix_d;
  logic             frame_q, frame_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             adv_c;
  logic [RGB_W-1:0] pix_rgb_c;

`ifdef VGA_TEST_PATTERN_EN
  // Colour bars: each bit of the bar index drives one 4-bit colour channel.
  logic [CW-1:0] rel_c;
  logic [2:0]    idx_c;
  logic [RGB_W-1:0] unused_rgb_in;
  always_comb begin
    unused_rgb_in = rgb_in;
    rel_c     = h_q - CW'(H_DISP_START);
    idx_c     = 3'(rel_c / CW'(BAR_W));
    pix_rgb_c = {{4{idx_c[2]}}, {4{idx_c[1]}}, {4{idx_c[0]}}};
  end
`else
  assign pix_rgb_c = rgb_in;
`endif

  // Divider, raster counters and one-pixel-delayed output stage.
  always_comb begin
    adv_c    = (div_q == DIV_W'(CLK_DIV - 1));
    div_d    = adv_c ? '0 : div_q + DIV_W'(1);
    h_d      = h_q;
    v_d      = v_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    rgb_d    = rgb_q;
    frame_d  = 1'b0;
    if (adv_c) begin
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
      frame_d = (h_q == CW'(H_TOTAL - 1)) && (v_q == CW'(V_TOTAL - 1));
      // Pixel stage samples the pre-advance position.
      hs_d  = ~(h_q < CW'(H_SYNC));
      vs_d  = ~(v_q < CW'(V_SYNC));
      rgb_d = bright_q ? pix_rgb_c : '0;
    end
    pix_d    = (div_d == DIV_W'(CLK_DIV - 1));
    // Computed from next-count values so bright tracks hCount/vCount exactly.
    bright_d = (h_d >= CW'(H_DISP_START)) && (h_d < CW'(H_DISP_END)) &&
               (v_d >= CW'(V_DISP_START)) && (v_d < CW'(V_DISP_END));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      bright_q <= 1'b0;
      pix_q    <= 1'b0;
      frame_q  <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      bright_q <= bright_d;
      pix_q    <= pix_d;
      frame_q  <= frame_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = bright_q;
  assign pix_tick   = pix_q;
  assign frame_tick = frame_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Instance B uses default 640x480 timing and
// is checked against a table of line/frame timing points; instance A uses a
// miniature raster and is checked every clk against an arithmetic model
// under random rgb_in, including a mid-frame asynchronous reset.
module tb_vga_timing_gen;

  localparam int unsigned AD = 3, AH = 24, AHS = 4, AHDS = 6, AHDE = 22;
  localparam int unsigned AV = 10, AVS = 2, AVDS = 3, AVDE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  ha, va, hb, vb;
  logic        bra, pta, fta, hsa, vsa, brb, ptb, ftb, hsb, vsb;
  logic [11:0] rgbo_a, rgbo_b;

  vga_timing_gen #(
    .CLK_DIV(AD), .H_TOTAL(AH), .H_SYNC(AHS), .H_DISP_START(AHDS),
    .H_DISP_END(AHDE), .V_TOTAL(AV), .V_SYNC(AVS), .V_DISP_START(AVDS),
    .V_DISP_END(AVDE)
  ) u_a (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_a), .hCount(ha), .vCount(va),
    .bright(bra), .pix_tick(pta), .frame_tick(fta), .hSync(hsa),
    .vSync(vsa), .rgb_out(rgbo_a)
  );

  vga_timing_gen u_b (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_b), .hCount(hb), .vCount(vb),
    .bright(brb), .pix_tick(ptb), .frame_tick(ftb), .hSync(hsb),
    .vSync(vsb), .rgb_out(rgbo_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at clk %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // ---------------- model for instance A ----------------
  int          ka;
  logic [11:0] last_rgb;

  function automatic logic vis(input int h, input int v);
    return (h >= AHDS) && (h < AHDE) && (v >= AVDS) && (v < AVDE);
  endfunction

  function automatic logic [11:0] colour(input int h);
`ifdef VGA_TEST_PATTERN_EN
    int idx = ((h - AHDS) / ((AHDE - AHDS) / 8)) % 8;
    logic [11:0] c = '0;
    for (int b = 0; b < 3; b++)
      if (((idx >> b) & 1) == 1) c = c | (12'hF << (4 * b));
    return c;
`else
    return (h < 0) ? 12'h000 : last_rgb;
`endif
  endfunction

  // Pixel n = k / AD elapsed since reset release; everything follows from n.
  task automatic model_check(input int k);
    int n = k / AD;
    int h = n % AH;
    int v = (n / AH) % AV;
    int ph, pv;
    chk("hCount", k, 32'(ha), 32'(h));
    chk("vCount", k, 32'(va), 32'(v));
    chk("bright", k, 32'(bra), 32'(vis(h, v)));
    chk("pix_tick", k, 32'(pta), 32'((k % AD) == AD - 1));
    chk("frame_tick", k, 32'(fta),
        32'(((k % AD) == 0) && (n > 0) && ((n % (AH * AV)) == 0)));
    if (n == 0) begin
      chk("hSync", k, 32'(hsa), 32'(1));
      chk("vSync", k, 32'(vsa), 32'(1));
      chk("rgb_out", k, 32'(rgbo_a), 32'(0));
    end else begin
      ph = (n - 1) % AH;
      pv = ((n - 1) / AH) % AV;
      chk("hSync", k, 32'(hsa), 32'(!(ph < AHS)));
      chk("vSync", k, 32'(vsa), 32'(!(pv < AVS)));
      chk("rgb_out", k, 32'(rgbo_a), 32'(vis(ph, pv) ? colour(ph) : 12'h000));
    end
  endtask

  // Enter at a negedge with ka = 0 just after release; leave at a negedge.
  task automatic run_a(input int cycles);
    int fcnt = 0;
    for (int c = 0; c < cycles; c++) begin
      model_check(ka);
      if (fta) fcnt++;
      rgb_a = 12'($urandom);
      @(posedge clk);
      if ((ka % AD) == AD - 1) last_rgb = rgb_a;
      ka++;
      @(negedge clk);
    end
    chk("frame_count", ka, 32'(fcnt), 32'(((cycles - 1) / AD) / (AH * AV)));
  endtask

  task automatic chk_reset_a(input int tag);
    chk("rst_hCount", tag, 32'(ha), 32'(0));
    chk("rst_vCount", tag, 32'(va), 32'(0));
    chk("rst_bright", tag, 32'(bra), 32'(0));
    chk("rst_pix_tick", tag, 32'(pta), 32'(0));
    chk("rst_frame_tick", tag, 32'(fta), 32'(0));
    chk("rst_hSync", tag, 32'(hsa), 32'(1));
    chk("rst_vSync", tag, 32'(vsa), 32'(1));
    chk("rst_rgb_out", tag, 32'(rgbo_a), 32'(0));
  endtask

  // ---------------- timing table for instance B ----------------
  typedef struct {
    int          k;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        pt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int k, input int h, input int v,
                              input logic hs, input logic vs, input logic pt);
    vec_t e;
    e.k = k; e.h = 10'(h); e.v = 10'(v); e.hs = hs; e.vs = vs; e.pt = pt;
    tbl.push_back(e);
  endfunction

  int kb;

  initial begin
    // k = clks since release; pixel = k/4.
    add(0,    0,   0, 1'b1, 1'b1, 1'b0);
    add(3,    0,   0, 1'b1, 1'b1, 1'b1);
    add(4,    1,   0, 1'b0, 1'b0, 1'b0);
    add(383,  95,  0, 1'b0, 1'b0, 1'b1);
    add(384,  96,  0, 1'b0, 1'b0, 1'b0);
    add(388,  97,  0, 1'b1, 1'b0, 1'b0);
    add(576,  144, 0, 1'b1, 1'b0, 1'b0);
    add(3196, 799, 0, 1'b1, 1'b0, 1'b0);
    add(3200, 0,   1, 1'b1, 1'b0, 1'b0);
    add(3204, 1,   1, 1'b0, 1'b0, 1'b0);
    add(6400, 0,   2, 1'b1, 1'b0, 1'b0);
    add(6404, 1,   2, 1'b0, 1'b1, 1'b0);

    rst_a = 1'b0; rst_b = 1'b0;
    rgb_a = 12'hABC; rgb_b = 12'hF0F;
    last_rgb = '0;
    @(negedge clk);
    chk_reset_a(-1);
    chk("rst_b_hSync", -1, 32'(hsb), 32'(1));
    chk("rst_b_rgb_out", -1, 32'(rgbo_b), 32'(0));

    // Instance B: default timing points, constant rgb_in, all lines blanked.
    rst_b = 1'b1; kb = 0;
    foreach (tbl[i]) begin
      while (kb < tbl[i].k) begin
        @(posedge clk); kb++; @(negedge clk);
        if (ftb) chk("b_frame_tick", kb, 32'(ftb), 32'(0));
        if (rgbo_b != 12'h000) chk("b_rgb_blank", kb, 32'(rgbo_b), 32'(0));
      end
      chk("b_hCount", kb, 32'(hb), 32'(tbl[i].h));
      chk("b_vCount", kb, 32'(vb), 32'(tbl[i].v));
      chk("b_hSync", kb, 32'(hsb), 32'(tbl[i].hs));
      chk("b_vSync", kb, 32'(vsb), 32'(tbl[i].vs));
      chk("b_pix_tick", kb, 32'(ptb), 32'(tbl[i].pt));
      chk("b_bright", kb, 32'(brb), 32'(0));
      chk("b_rgb_out", kb, 32'(rgbo_b), 32'(0));
    end
    rst_b = 1'b0;

    // Instance A: three-plus frames of random colour against the model.
    rst_a = 1'b1; ka = 0;
    run_a(2500);

    // Mid-pixel asynchronous reset: outputs must clear before any clk edge.
    #2 rst_a = 1'b0;
    #1 chk_reset_a(-2);
    @(negedge clk);
    chk_reset_a(-3);
    rst_a = 1'b1; ka = 0;
    run_a(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
